// File: rtl/wbm_cmd_master_if.sv
// wbm_cmd_master_if: command/response port plus Wishbone master bus of wbm_cmd_master.
// The master modport is the bus master's view; slave is the fabric/interconnect side.
interface wbm_cmd_master_if #(
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 8
);
    logic                          cmd_valid_i;
    logic                          cmd_ready_o;
    logic                          cmd_we_i;
    logic [BUS_ADDR_WIDTH-1:0]     cmd_adr_i;
    logic [BUS_DATA_WIDTH-1:0]     cmd_dat_i;
    logic [BUS_DATA_WIDTH/8-1:0]   cmd_sel_i;
    logic                          rsp_valid_o;
    logic [BUS_DATA_WIDTH-1:0]     rsp_dat_o;
    logic                          rsp_err_o;
    logic                          rsp_timeout_o;
    logic                          wbm_cyc_o;
    logic                          wbm_stb_o;
    logic                          wbm_we_o;
    logic [BUS_DATA_WIDTH/8-1:0]   wbm_sel_o;
    logic [BUS_ADDR_WIDTH-1:0]     wbm_adr_o;
    logic [BUS_DATA_WIDTH-1:0]     wbm_dat_o;
    logic [BUS_DATA_WIDTH-1:0]     wbm_dat_i;
    logic                          wbm_ack_i;
    logic                          wbm_err_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );
endinterface

// File: rtl/wbm_cmd_master.sv
// wbm_cmd_master: Wishbone classic single-transfer master driven by a valid/ready command port.
// Define WBM_TIMEOUT_EN to abort cycles left unanswered for TIMEOUT_CYCLES cycles.
module wbm_cmd_master #(
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic              wb_clk_i,
    input logic              wb_rst_n_i,
    wbm_cmd_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUS, RELEASE} state_t;

    state_t state;
    logic   timed_out;

`ifdef WBM_TIMEOUT_EN
    localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt;
    assign timed_out = cnt == LAST;
`else
    assign timed_out = 1'b0;
    assign bus.rsp_timeout_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state           <= IDLE;
            bus.cmd_ready_o <= 1'b0;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_dat_o   <= {BUS_DATA_WIDTH{1'b0}};
            bus.rsp_err_o   <= 1'b0;
            bus.wbm_cyc_o   <= 1'b0;
            bus.wbm_stb_o   <= 1'b0;
            bus.wbm_we_o    <= 1'b0;
            bus.wbm_sel_o   <= {(BUS_DATA_WIDTH/8){1'b0}};
            bus.wbm_adr_o   <= {BUS_ADDR_WIDTH{1'b0}};
            bus.wbm_dat_o   <= {BUS_DATA_WIDTH{1'b0}};
`ifdef WBM_TIMEOUT_EN
            bus.rsp_timeout_o <= 1'b0;
            cnt               <= '0;
`endif
        end else begin
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_err_o   <= 1'b0;
`ifdef WBM_TIMEOUT_EN
            bus.rsp_timeout_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.cmd_valid_i && bus.cmd_ready_o) begin
                        bus.cmd_ready_o <= 1'b0;
                        bus.wbm_cyc_o   <= 1'b1;
                        bus.wbm_stb_o   <= 1'b1;
                        bus.wbm_we_o    <= bus.cmd_we_i;
                        bus.wbm_sel_o   <= bus.cmd_sel_i;
                        bus.wbm_adr_o   <= bus.cmd_adr_i;
                        bus.wbm_dat_o   <= bus.cmd_dat_i;
`ifdef WBM_TIMEOUT_EN
                        cnt <= '0;
`endif
                        state <= BUS;
                    end else begin
                        bus.cmd_ready_o <= 1'b1;
                    end
                end
                BUS: begin
                    // ERR wins over a simultaneous ACK; read data is captured only on a clean read ACK
                    if (bus.wbm_err_i || bus.wbm_ack_i || timed_out) begin
                        bus.wbm_cyc_o   <= 1'b0;
                        bus.wbm_stb_o   <= 1'b0;
                        bus.wbm_we_o    <= 1'b0;
                        bus.rsp_valid_o <= 1'b1;
                        bus.rsp_err_o   <= bus.wbm_err_i;
                        if (bus.wbm_ack_i && !bus.wbm_err_i && !bus.wbm_we_o)
                            bus.rsp_dat_o <= bus.wbm_dat_i;
`ifdef WBM_TIMEOUT_EN
                        bus.rsp_timeout_o <= !bus.wbm_err_i && !bus.wbm_ack_i;
`endif
                        state <= RELEASE;
                    end
`ifdef WBM_TIMEOUT_EN
                    else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RELEASE: begin
                    // slaves hold ACK until STB drops; wait it out so it cannot end the next cycle
                    if (!bus.wbm_ack_i && !bus.wbm_err_i) begin
                        bus.cmd_ready_o <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wbm_cmd_master.sv
// tb_wbm_cmd_master: scoreboard bench for wbm_cmd_master against a byte-enabled register slave.
// Honours WBM_TIMEOUT_EN the same way as the design (TIMEOUT_CYCLES = 8).
module tb_wbm_cmd_master;
    typedef struct packed {
        logic [31:0] dat;
        logic        err;
        logic        to;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_pass = 0;
    rsp_t sb[$];

    logic        mute, err_mode;
    int          dly, hold, bc, hc;
    logic [31:0] mem [16];

    wbm_cmd_master_if #(.BUS_DATA_WIDTH(32), .BUS_ADDR_WIDTH(8)) bus ();

    wbm_cmd_master #(
        .BUS_DATA_WIDTH(32),
        .BUS_ADDR_WIDTH(8),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Registered slave: responds after dly stb-cycles, holds ack/err hold cycles after stb drops
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wbm_ack_i <= 1'b0;
            bus.wbm_err_i <= 1'b0;
            bus.wbm_dat_i <= 32'h0;
            bc <= 0;
            hc <= 0;
        end else if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
            hc <= 0;
            bc <= bc + 1;
            if (!bus.wbm_ack_i && !bus.wbm_err_i && !mute && bc == dly) begin
                if (err_mode) begin
                    bus.wbm_err_i <= 1'b1;
                end else begin
                    bus.wbm_ack_i <= 1'b1;
                    if (bus.wbm_we_o) begin
                        for (int i = 0; i < 4; i++)
                            if (bus.wbm_sel_o[i])
                                mem[bus.wbm_adr_o[3:0]][8*i +: 8] <= bus.wbm_dat_o[8*i +: 8];
                    end else begin
                        bus.wbm_dat_i <= mem[bus.wbm_adr_o[3:0]];
                    end
                end
            end
        end else begin
            bc <= 0;
            if ((bus.wbm_ack_i || bus.wbm_err_i) && hc < hold) begin
                hc <= hc + 1;
            end else begin
                bus.wbm_ack_i <= 1'b0;
                bus.wbm_err_i <= 1'b0;
                hc <= 0;
            end
        end
    end

    always @(negedge clk) begin
        rsp_t e;
        if (rst_n && bus.rsp_valid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", bus.rsp_valid_o, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("rsp_dat_err_to", {bus.rsp_dat_o, bus.rsp_err_o, bus.rsp_timeout_o}, e);
            end
            chk("cyc_low_on_rsp", bus.wbm_cyc_o, 1'b0);
        end
    end

    task automatic send(input logic we, input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        int k = 0;
        @(negedge clk);
        while (!bus.cmd_ready_o && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("cmd_ready", bus.cmd_ready_o, 1'b1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_adr_i   = adr;
        bus.cmd_dat_i   = dat;
        bus.cmd_sel_i   = sel;
        @(posedge clk);
        #1 bus.cmd_valid_i = 1'b0;
    endtask

    task automatic xfer(input logic we, input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                        input logic [31:0] edat, input logic eerr, input logic eto, output int cyc_n);
        int k = 0;
        send(we, adr, dat, sel);
        sb.push_back('{edat, eerr, eto});
        cyc_n = 0;
        while (k < 2000) begin
            @(negedge clk);
            if (bus.rsp_valid_o) break;
            if (bus.wbm_cyc_o) cyc_n++;
            k++;
        end
        chk("rsp_arrived", bus.rsp_valid_o, 1'b1);
    endtask

    initial begin
        int n, k;
        rst_n = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = 8'h0;
        bus.cmd_dat_i   = 32'h0;
        bus.cmd_sel_i   = 4'h0;
        mute = 1'b0;
        err_mode = 1'b0;
        dly = 0;
        hold = 0;
        #1;
        chk("reset_ready", bus.cmd_ready_o, 1'b0);
        chk("reset_cyc_stb_we", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o}, 3'b000);
        chk("reset_rsp", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o}, 3'b000);
        chk("reset_rsp_dat", bus.rsp_dat_o, 32'h0);
        chk("reset_adr_dat_sel", {bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_sel_o}, 44'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_reset", bus.cmd_ready_o, 1'b1);

        xfer(1'b1, 8'h00, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0, n);
        chk("write_cyc_len", n, 2);
        xfer(1'b0, 8'h00, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, n);
        chk("read_cyc_len", n, 2);
        xfer(1'b1, 8'h00, 32'h0000AA00, 4'h2, 32'hDEADBEEF, 1'b0, 1'b0, n);
        xfer(1'b0, 8'h00, 32'h0, 4'hF, 32'hDEADAAEF, 1'b0, 1'b0, n);

        hold = 3;
        xfer(1'b0, 8'h00, 32'h0, 4'hF, 32'hDEADAAEF, 1'b0, 1'b0, n);
        k = 0;
        while (bus.wbm_ack_i && k < 20) begin
            chk("ready_low_stale_ack", bus.cmd_ready_o, 1'b0);
            @(negedge clk);
            k++;
        end
        chk("stale_ack_cycles", k, 4);
        hold = 0;
        dly = 2;
        xfer(1'b0, 8'h00, 32'h0, 4'hF, 32'hDEADAAEF, 1'b0, 1'b0, n);
        chk("after_stale_cyc_len", n, 4);

        dly = 1;
        err_mode = 1'b1;
        xfer(1'b0, 8'h00, 32'h0, 4'hF, 32'hDEADAAEF, 1'b1, 1'b0, n);
        chk("err_cyc_len", n, 3);
        err_mode = 1'b0;
        dly = 0;

`ifdef WBM_TIMEOUT_EN
        mute = 1'b1;
        xfer(1'b0, 8'h00, 32'h0, 4'hF, 32'hDEADAAEF, 1'b0, 1'b1, n);
        chk("timeout_cyc_len", n, 8);
        mute = 1'b0;
        xfer(1'b0, 8'h00, 32'h0, 4'hF, 32'hDEADAAEF, 1'b0, 1'b0, n);
        chk("post_timeout_cyc_len", n, 2);
        mute = 1'b1;
        send(1'b0, 8'h00, 32'h0, 4'hF);
        repeat (3) @(negedge clk);
`else
        mute = 1'b1;
        send(1'b0, 8'h00, 32'h0, 4'hF);
        k = 0;
        repeat (1000) begin
            @(negedge clk);
            if (bus.wbm_cyc_o) k++;
        end
        chk("cyc_held_no_timeout", k, 1000);
`endif

        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_cyc_stb", {bus.wbm_cyc_o, bus.wbm_stb_o}, 2'b00);
        chk("midreset_ready_rsp", {bus.cmd_ready_o, bus.rsp_valid_o}, 2'b00);
        #3 rst_n = 1'b1;
        mute = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_midreset", bus.cmd_ready_o, 1'b1);
        xfer(1'b0, 8'h00, 32'h0, 4'hF, 32'hDEADAAEF, 1'b0, 1'b0, n);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
